bitonic_sort_stream: RTL and testbench

BITONIC_SORT_STREAM -- requirements
Module: bitonic_sort_stream

---
 rtl/bitonic_sort_stream.sv | 127 ++++++++++++
 tb/tb_bitonic_sort_stream.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitonic_sort_stream.sv
// Streaming stable vector sorter: odd-even transposition, one phase per cycle, tags track origin.
// Optional SORT_EARLY_EXIT_EN: finish once two consecutive phases perform no swaps.
module bitonic_sort_stream #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int IW    = $clog2(DEPTH),
  localparam int PW    = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DEPTH-1:0][WIDTH-1:0] in_data,
  input  logic                        in_desc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DEPTH-1:0][WIDTH-1:0] out_data,
  output logic [DEPTH-1:0][IW-1:0]    out_idx,
  output logic [PW-1:0]               out_phases,
  output logic [1:0]                  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready depends only on state; out_valid holds with stable data until accepted.
  typedef enum logic [1:0] {IDLE = 2'd0, SORT = 2'd1, DONE = 2'd2} state_t;

  state_t                      state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d, ex_data;
  logic [DEPTH-1:0][IW-1:0]    tag_q, tag_d, ex_tag;
  logic                        desc_q, desc_d;
  logic [PW-1:0]               phase_q, phase_d;
  logic                        zero_q, zero_d;
  logic                        any_swap;
  logic                        swap;

  // One compare-exchange phase; pairs are disjoint so every read is from the registered vector.
  always_comb begin
    ex_data  = data_q;
    ex_tag   = tag_q;
    any_swap = 1'b0;
    swap     = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (i[0] == phase_q[0]) begin
        swap = desc_q ? (data_q[i] < data_q[i+1]) : (data_q[i] > data_q[i+1]);
        if (swap) begin
          ex_data[i]   = data_q[i+1];
          ex_data[i+1] = data_q[i];
          ex_tag[i]    = tag_q[i+1];
          ex_tag[i+1]  = tag_q[i];
          any_swap     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tag_d   = tag_q;
    desc_d  = desc_q;
    phase_d = phase_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          desc_d  = in_desc;
          for (int i = 0; i < DEPTH; i++) tag_d[i] = IW'(i);
          phase_d = '0;
          zero_d  = 1'b0;
          state_d = SORT;
        end
      end
      SORT: begin
        data_d  = ex_data;
        tag_d   = ex_tag;
        phase_d = phase_q + 1'b1;
        zero_d  = !any_swap;
        if (phase_q == PW'(DEPTH - 1)) begin
          state_d = DONE;
        end
`ifdef SORT_EARLY_EXIT_EN
        else if (!any_swap && zero_q) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      tag_q   <= '0;
      desc_q  <= 1'b0;
      phase_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      desc_q  <= desc_d;
      phase_q <= phase_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == DONE);
    out_data   = '0;
    out_idx    = '0;
    out_phases = '0;
    dbg_state  = state_q;
    if (state_q == DONE) begin
      out_data   = data_q;
      out_idx    = tag_q;
      out_phases = phase_q;
    end
  end

endmodule

// File: tb/tb_bitonic_sort_stream.sv
// Self-checking bench for bitonic_sort_stream (WIDTH=32, DEPTH=8) against a stable insertion-sort model.
module tb_bitonic_sort_stream;
  localparam int W  = 32;
  localparam int D  = 8;
  localparam int IW = $clog2(D);
  localparam int PW = $clog2(D + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [D-1:0][W-1:0] in_data = '0;
  logic                in_desc = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [D-1:0][W-1:0] out_data;
  logic [D-1:0][IW-1:0] out_idx;
  logic [PW-1:0]       out_phases;
  logic [1:0]          dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [W-1:0]  exp_q[$];
  logic [IW-1:0] idx_q[$];

  bitonic_sort_stream #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_desc(in_desc), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_phases(out_phases), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Stable insertion sort: an element only moves past a neighbour that is strictly out of order.
  function automatic void model(input logic [D-1:0][W-1:0] v, input logic desc);
    logic [W-1:0]  vals[D];
    logic [IW-1:0] ids[D];
    logic [W-1:0]  tv;
    logic [IW-1:0] ti;
    int j;
    for (int i = 0; i < D; i++) begin vals[i] = v[i]; ids[i] = IW'(i); end
    for (int i = 1; i < D; i++) begin
      j = i;
      while (j > 0 && (desc ? (vals[j-1] < vals[j]) : (vals[j-1] > vals[j]))) begin
        tv = vals[j]; vals[j] = vals[j-1]; vals[j-1] = tv;
        ti = ids[j];  ids[j]  = ids[j-1];  ids[j-1]  = ti;
        j--;
      end
    end
    for (int i = 0; i < D; i++) begin exp_q.push_back(vals[i]); idx_q.push_back(ids[i]); end
  endfunction

  function automatic logic [D-1:0][W-1:0] pack(input int a[D]);
    logic [D-1:0][W-1:0] r;
    for (int i = 0; i < D; i++) r[i] = W'(a[i]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer a vector until accepted; drop in_valid afterwards unless keep is set.
  task automatic accept_vec(input logic [D-1:0][W-1:0] v, input logic desc, input logic keep,
                            input logic push);
    int n;
    in_data = v; in_desc = desc; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    vec_cnt++;
    if (!in_ready) begin
      err_cnt++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    if (push) model(v, desc);
    tick();
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin tick(); lat++; end while (!out_valid && lat < 50);
    vec_cnt++;
    if (!out_valid) begin
      err_cnt++;
      $display("FAIL out_valid_timeout: out_valid=%0b required 1", out_valid);
    end
  endtask

  task automatic check_out(input string name, input int lat);
    logic [D-1:0][W-1:0]  ed;
    logic [D-1:0][IW-1:0] ei;
    for (int i = 0; i < D; i++) begin ed[i] = exp_q.pop_front(); ei[i] = idx_q.pop_front(); end
    vec_cnt++;
    if (out_data !== ed) begin
      err_cnt++;
      $display("FAIL %s_data: got %h required %h", name, out_data, ed);
    end
    vec_cnt++;
    if (out_idx !== ei) begin
      err_cnt++;
      $display("FAIL %s_idx: got %h required %h", name, out_idx, ei);
    end
    vec_cnt++;
    if (out_phases !== PW'(lat)) begin
      err_cnt++;
      $display("FAIL %s_phases: got %0d required %0d", name, out_phases, lat);
    end
`ifndef SORT_EARLY_EXIT_EN
    vec_cnt++;
    if (lat != D) begin
      err_cnt++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, D);
    end
`else
    vec_cnt++;
    if (lat > D || lat < 2) begin
      err_cnt++;
      $display("FAIL %s_latency: got %0d required 2..%0d", name, lat, D);
    end
`endif
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL handshake_release: out_valid=%0b required 0", out_valid);
    end
  endtask

  task automatic run_vec(input string name, input logic [D-1:0][W-1:0] v, input logic desc);
    int lat;
    accept_vec(v, desc, 1'b0, 1'b1);
    wait_out(lat);
    check_out(name, lat);
    handshake();
  endtask

  task automatic check_idle_zero(input string name);
    vec_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_idx !== '0 ||
        out_phases !== '0) begin
      err_cnt++;
      $display("FAIL %s: in_ready=%0b out_valid=%0b data=%h idx=%h phases=%0d required 1/0/zeros",
               name, in_ready, out_valid, out_data, out_idx, out_phases);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_idle_zero("reset_state");
  endtask

  task automatic test_directed();
    int a[D] = '{7, 3, 5, 1, 8, 2, 6, 4};
    int b[D] = '{2, 1, 2, 1, 2, 1, 2, 1};
    run_vec("asc_basic", pack(a), 1'b0);
    run_vec("desc_basic", pack(a), 1'b1);
    run_vec("stable_ties", pack(b), 1'b0);
    run_vec("stable_ties_desc", pack(b), 1'b1);
  endtask

  task automatic test_random();
    logic [D-1:0][W-1:0] v;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < D; i++)
        v[i] = (n % 2 == 0) ? W'($urandom_range(0, 3)) : $urandom();
      if (n == 5) v = '1;
      run_vec("random", v, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_sorted_input();
    int a[D] = '{0, 1, 2, 3, 4, 5, 6, 7};
    int lat;
    accept_vec(pack(a), 1'b0, 1'b0, 1'b1);
    wait_out(lat);
    vec_cnt++;
`ifdef SORT_EARLY_EXIT_EN
    if (lat != 2) begin
      err_cnt++;
      $display("FAIL early_exit_latency: got %0d required 2", lat);
    end
`else
    if (lat != D) begin
      err_cnt++;
      $display("FAIL full_latency: got %0d required %0d", lat, D);
    end
`endif
    check_out("sorted_in", lat);
    handshake();
  endtask

  task automatic test_backpressure();
    int a[D] = '{7, 3, 5, 1, 8, 2, 6, 4};
    int b[D] = '{9, 9, 0, 4, 4, 1, 3, 9};
    logic [D-1:0][W-1:0] snap_d;
    logic [D-1:0][IW-1:0] snap_i;
    int lat;
    int bad;
    accept_vec(pack(a), 1'b0, 1'b1, 1'b1);
    in_data = pack(b); in_desc = 1'b1;
    wait_out(lat);
    check_out("bp_first", lat);
    snap_d = out_data; snap_i = out_idx;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== snap_d || out_idx !== snap_i)
        bad++;
    end
    vec_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL bp_hold: %0d cycles changed, required 0", bad);
    end
    model(pack(b), 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vec_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL bp_release: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    check_out("bp_second", lat);
    handshake();
  endtask

  task automatic test_back_to_back();
    int a[D] = '{5, 0, 5, 2, 7, 7, 1, 3};
    int hits[$];
    int gap_bad;
    in_data = pack(a); in_desc = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (out_valid) begin
        hits.push_back(c);
        model(pack(a), 1'b0);
        check_out("b2b", int'(out_phases));
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    gap_bad = 0;
    for (int i = 1; i < hits.size(); i++) if (hits[i] - hits[i-1] != D + 2) gap_bad++;
    vec_cnt++;
    if (hits.size() < 3 || gap_bad != 0) begin
      err_cnt++;
      $display("FAIL b2b_throughput: %0d results, %0d bad gaps, required >=3 results spaced %0d",
               hits.size(), gap_bad, D + 2);
    end
  endtask

  task automatic test_reset_mid_sort();
    int a[D] = '{7, 3, 5, 1, 8, 2, 6, 4};
    int seen;
    accept_vec(pack(a), 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("reset_mid_sort");
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin tick(); if (out_valid) seen++; end
    out_ready = 1'b0;
    vec_cnt++;
    if (seen != 0) begin
      err_cnt++;
      $display("FAIL reset_discard: out_valid seen %0d cycles, required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sorted_input();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_sort();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
